vout_timing_gen: RTL and testbench

//  Output-side video timing generator: drives vout_hs/vs/de (consumed by fantasy and the HDMI TX) on vout_clk_i.

---
 rtl/video_timing_pkg.sv | 22 ++
 rtl/sync_edge.sv | 21 ++
 rtl/vout_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_vout_timing_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing types and default 1080p60 raster constants.
package video_timing_pkg;

   typedef enum logic [1:0] {
      FREE,
      SEEK,
      LOCKED
   } genlock_state_e;

   localparam int VT_H_WIDTH   = 1920;
   localparam int VT_H_START   = 2008;
   localparam int VT_H_SYNC    = 44;
   localparam int VT_H_TOTAL   = 2200;
   localparam int VT_V_HEIGHT  = 1080;
   localparam int VT_V_START   = 1084;
   localparam int VT_V_SYNC    = 5;
   localparam int VT_V_TOTAL   = 1125;
   localparam bit VT_SYNC_POL  = 1'b1;
   localparam int VT_LOCK_LINE = 1084;
   localparam int VT_MISS_MAX  = 3;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus edge detect: one-clock pulse when the input moves to SYNC_POL.
// Pulse appears two clocks after the input is first sampled; no backpressure.
module sync_edge #(
   parameter bit SYNC_POL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic d_i,
   output logic edge_o
);

   logic [2:0] sr;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) sr <= {3{~SYNC_POL}};
      else        sr <= {sr[1:0], d_i};
   end

   assign edge_o = (sr[1] == SYNC_POL) && (sr[2] != SYNC_POL);

endmodule

// File: rtl/vout_timing_gen.sv
// Output video timing generator: free-running raster with optional genlock to the input vsync.
// Outputs are registered one clock behind the internal counters; no backpressure.
module vout_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_WIDTH   = VT_H_WIDTH,
   parameter int H_START   = VT_H_START,
   parameter int H_SYNC    = VT_H_SYNC,
   parameter int H_TOTAL   = VT_H_TOTAL,
   parameter int V_HEIGHT  = VT_V_HEIGHT,
   parameter int V_START   = VT_V_START,
   parameter int V_SYNC    = VT_V_SYNC,
   parameter int V_TOTAL   = VT_V_TOTAL,
   parameter bit SYNC_POL  = VT_SYNC_POL,
   parameter int LOCK_LINE = VT_LOCK_LINE,
   parameter int MISS_MAX  = VT_MISS_MAX,
   localparam int HW = $clog2(H_TOTAL),
   localparam int VW = $clog2(V_TOTAL)
) (
   input  logic          vout_clk_i,
   input  logic          rst_n,
   input  logic          lock_en_i,
   input  logic          vin_vs_i,
   output logic          vout_hs_o,
   output logic          vout_vs_o,
   output logic          vout_de_o,
   output logic [HW-1:0] hcnt_o,
   output logic [VW-1:0] vcnt_o,
   output logic          frame_start_o,
   output logic          locked_o
);

   localparam int MW = (MISS_MAX > 1) ? $clog2(MISS_MAX) : 1;

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT     = HW'(H_WIDTH);
   localparam logic [HW-1:0] H_SS      = HW'(H_START);
   localparam logic [HW-1:0] H_SW      = HW'(H_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT     = VW'(V_HEIGHT);
   localparam logic [VW-1:0] V_SS      = VW'(V_START);
   localparam logic [VW-1:0] V_SW      = VW'(V_SYNC);
   localparam logic [VW-1:0] V_LOCK    = VW'(LOCK_LINE);
   localparam logic [VW:0]   V_TOT     = (VW+1)'(V_TOTAL);
   localparam logic [VW:0]   V_TOTM1   = (VW+1)'(V_TOTAL - 1);
   localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

   if (H_START + H_SYNC > H_TOTAL) begin : g_bad_hsync
      $error("hsync extends past the end of the line");
   end
   if (H_WIDTH > H_START) begin : g_bad_hact
      $error("active width overlaps hsync");
   end
   if (V_START + V_SYNC > V_TOTAL) begin : g_bad_vsync
      $error("vsync extends past the end of the frame");
   end
   if (V_HEIGHT > V_START) begin : g_bad_vact
      $error("active height overlaps vsync");
   end
   if (LOCK_LINE >= V_TOTAL) begin : g_bad_lock
      $error("LOCK_LINE outside the frame");
   end

   genlock_state_e state, state_nxt;
   logic [HW-1:0]  hcnt, hcnt_nxt;
   logic [VW-1:0]  vcnt, vcnt_nxt;
   logic [MW-1:0]  miss, miss_nxt;
   logic           pend, pend_nxt;
   logic           vedge, line_end, realign, in_phase;
   logic [VW:0]    vdiff;

   sync_edge #(.SYNC_POL(SYNC_POL)) u_vin_sync (
      .clk_i  (vout_clk_i),
      .rst_n  (rst_n),
      .d_i    (vin_vs_i),
      .edge_o (vedge)
   );

   assign line_end = (hcnt == H_LAST);

   // Distance from the lock line, modulo the frame height
   assign vdiff    = (vcnt >= V_LOCK) ? {1'b0, vcnt - V_LOCK}
                                      : {1'b0, vcnt} + V_TOT - {1'b0, V_LOCK};
   assign in_phase = (vdiff <= (VW+1)'(1)) || (vdiff == V_TOTM1);

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      miss_nxt  = miss;
      realign   = 1'b0;
      if (!lock_en_i) begin
         state_nxt = FREE;
         pend_nxt  = 1'b0;
         miss_nxt  = '0;
      end else begin
         case (state)
            FREE: state_nxt = SEEK;
            SEEK: begin
               // Jump only at a line end so no runt hsync or partial de line is produced
               if (line_end && (pend || vedge)) begin
                  realign   = 1'b1;
                  pend_nxt  = 1'b0;
                  state_nxt = LOCKED;
               end else if (vedge) begin
                  pend_nxt = 1'b1;
               end
            end
            LOCKED: begin
               if (vedge) begin
                  if (in_phase) begin
                     miss_nxt = '0;
                  end else if (miss == MISS_LAST) begin
                     miss_nxt  = '0;
                     state_nxt = SEEK;
                  end else begin
                     miss_nxt = miss + 1'b1;
                  end
               end
            end
            default: state_nxt = FREE;
         endcase
      end

      if (realign) begin
         hcnt_nxt = '0;
         vcnt_nxt = V_LOCK;
      end else if (line_end) begin
         hcnt_nxt = '0;
         vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt_nxt = hcnt + 1'b1;
         vcnt_nxt = vcnt;
      end
   end

   always_ff @(posedge vout_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= FREE;
         pend  <= 1'b0;
         miss  <= '0;
         hcnt  <= '0;
         vcnt  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
         miss  <= miss_nxt;
         hcnt  <= hcnt_nxt;
         vcnt  <= vcnt_nxt;
      end
   end

   always_ff @(posedge vout_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_o        <= '0;
         vcnt_o        <= '0;
         vout_de_o     <= 1'b0;
         vout_hs_o     <= ~SYNC_POL;
         vout_vs_o     <= ~SYNC_POL;
         frame_start_o <= 1'b0;
      end else begin
         hcnt_o        <= hcnt;
         vcnt_o        <= vcnt;
         vout_de_o     <= (hcnt < H_ACT) && (vcnt < V_ACT);
         vout_hs_o     <= ((hcnt >= H_SS) && ((hcnt - H_SS) < H_SW)) ? SYNC_POL : ~SYNC_POL;
         vout_vs_o     <= ((vcnt >= V_SS) && ((vcnt - V_SS) < V_SW)) ? SYNC_POL : ~SYNC_POL;
         frame_start_o <= (hcnt == '0) && (vcnt == '0);
      end
   end

   assign locked_o = (state == LOCKED);

endmodule

// File: tb/tb_vout_timing_gen.sv
// Scoreboard bench for vout_timing_gen on a 12x7 raster with a position-based reference model.
module tb_vout_timing_gen;

   localparam int HT = 12, HA = 8, HS = 10, HSW = 2;
   localparam int VT = 7,  VA = 4, VS = 5,  VSW = 1;
   localparam int LL = 5,  MM = 3;
   localparam int M_FREE = 0, M_SEEK = 1, M_LOCKED = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lock_en = 1'b0;
   logic       vin = 1'b0;
   logic       hs, vs, de, fs, locked;
   logic [3:0] hcnt;
   logic [2:0] vcnt;

   always #5 clk = ~clk;

   vout_timing_gen #(
      .H_WIDTH(HA), .H_START(HS), .H_SYNC(HSW), .H_TOTAL(HT),
      .V_HEIGHT(VA), .V_START(VS), .V_SYNC(VSW), .V_TOTAL(VT),
      .SYNC_POL(1'b1), .LOCK_LINE(LL), .MISS_MAX(MM)
   ) dut (
      .vout_clk_i    (clk),
      .rst_n         (rst_n),
      .lock_en_i     (lock_en),
      .vin_vs_i      (vin),
      .vout_hs_o     (hs),
      .vout_vs_o     (vs),
      .vout_de_o     (de),
      .hcnt_o        (hcnt),
      .vcnt_o        (vcnt),
      .frame_start_o (fs),
      .locked_o      (locked)
   );

   typedef struct packed {
      logic       hs, vs, de, fs, locked;
      logic [3:0] h;
      logic [2:0] v;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0, n_err = 0;
   int   hs_run = 0;

   // Reference model: raster position as a single pixel index within the frame
   int m_h = 0, m_v = 0, m_st = M_FREE, m_pend = 0, m_miss = 0;
   bit samp[$] = '{1'b0, 1'b0, 1'b0};

   task automatic model_step();
      exp_t e;
      bit   vedge, realign;
      int   d, pos;
      if (!rst_n) begin
         m_h = 0; m_v = 0; m_st = M_FREE; m_pend = 0; m_miss = 0;
         samp = '{1'b0, 1'b0, 1'b0};
         e = '{hs: 1'b0, vs: 1'b0, de: 1'b0, fs: 1'b0, locked: 1'b0, h: 4'd0, v: 3'd0};
      end else begin
         // samp holds the vin samples from three, two and one clocks ago
         vedge   = samp[1] && !samp[0];
         realign = 1'b0;
         e.h  = 4'(m_h);
         e.v  = 3'(m_v);
         e.de = (m_h < HA) && (m_v < VA);
         e.hs = (m_h >= HS) && (m_h < HS + HSW);
         e.vs = (m_v >= VS) && (m_v < VS + VSW);
         e.fs = (m_h == 0) && (m_v == 0);
         if (!lock_en) begin
            m_st = M_FREE; m_pend = 0; m_miss = 0;
         end else if (m_st == M_FREE) begin
            m_st = M_SEEK;
         end else if (m_st == M_SEEK) begin
            if (vedge) m_pend = 1;
            if (m_h == HT - 1 && m_pend != 0) begin
               realign = 1'b1; m_pend = 0; m_st = M_LOCKED;
            end
         end else if (vedge) begin
            d = (m_v - LL + VT) % VT;
            if (d <= 1 || d == VT - 1) m_miss = 0;
            else begin
               m_miss++;
               if (m_miss == MM) begin m_miss = 0; m_st = M_SEEK; end
            end
         end
         if (realign) begin
            m_h = 0; m_v = LL;
         end else begin
            pos = (m_v * HT + m_h + 1) % (HT * VT);
            m_h = pos % HT;
            m_v = pos / HT;
         end
         e.locked = (m_st == M_LOCKED);
         samp.push_back(vin);
         void'(samp.pop_front());
      end
      sbq.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e, got;
      @(negedge clk);
      if (sbq.size() > 0) begin
         e   = sbq.pop_front();
         got = '{hs: hs, vs: vs, de: de, fs: fs, locked: locked, h: hcnt, v: vcnt};
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL scoreboard @%0t: got hs%b vs%b de%b fs%b lk%b h%0d v%0d, expected hs%b vs%b de%b fs%b lk%b h%0d v%0d",
                     $time, got.hs, got.vs, got.de, got.fs, got.locked, got.h, got.v,
                     e.hs, e.vs, e.de, e.fs, e.locked, e.h, e.v);
         end
      end
      if (!rst_n) hs_run = 0;
      else if (hs) hs_run++;
      else if (hs_run != 0) begin
         n_cmp++;
         if (hs_run != HSW) begin
            n_err++;
            $display("FAIL hs_width @%0t: got %0d clocks, expected %0d", $time, hs_run, HSW);
         end
         hs_run = 0;
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_pos(input int h, input int v);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         hit = (m_h == h) && (m_v == v);
      end
      if (!hit) begin
         n_cmp++; n_err++;
         $display("FAIL wait_pos: position h%0d v%0d not reached within 200 clocks", h, v);
      end
      #1;
   endtask

   task automatic vs_pulse(input int line);
      wait_pos($urandom_range(0, 5), line);
      vin = 1'b1;
      cyc($urandom_range(1, 8));
      vin = 1'b0;
      cyc(20);
   endtask

   initial begin
      int de_cnt, hs_cnt, vs_cnt, fs_cnt;
      cyc(3);
      rst_n = 1'b1;

      // Free-run: vin activity must be ignored
      repeat (30) begin
         vin = 1'($urandom_range(0, 1));
         cyc(1);
      end
      vin = 1'b0;
      cyc(10);
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
      repeat (HT * VT) begin
         @(negedge clk);
         de_cnt += int'(de); hs_cnt += int'(hs); vs_cnt += int'(vs); fs_cnt += int'(fs);
      end
      #1;
      check("de_per_frame", 8'(de_cnt), 8'(HA * VA));
      check("hs_per_frame", 8'(hs_cnt), 8'(HSW * VT));
      check("vs_per_frame", 8'(vs_cnt), 8'(HT * VSW));
      check("fs_per_frame", 8'(fs_cnt), 8'd1);

      // Asynchronous reset mid-frame on line 3
      wait_pos($urandom_range(0, 8), 3);
      rst_n = 1'b0;
      #1;
      check("rst_de", 8'(de), 8'd0);
      check("rst_hs", 8'(hs), 8'd0);
      check("rst_vs", 8'(vs), 8'd0);
      check("rst_hcnt", 8'(hcnt), 8'd0);
      cyc($urandom_range(1, 4));
      rst_n = 1'b1;
      @(negedge clk);
      check("first_de", 8'(de), 8'd1);
      check("first_hcnt", 8'(hcnt), 8'd0);
      check("first_vcnt", 8'(vcnt), 8'd0);
      check("first_fs", 8'(fs), 8'd1);
      #1;

      // Acquire lock from a pulse mid-line 1
      lock_en = 1'b1;
      cyc(2);
      wait_pos(4, 1);
      vin = 1'b1;
      cyc(3);
      vin = 1'b0;
      cyc(12);
      check("lock_acquired", 8'(locked), 8'd1);

      // In-phase pulses keep lock; three shifted pulses drop it
      repeat (10) vs_pulse(LL);
      check("lock_held", 8'(locked), 8'd1);
      repeat (3) vs_pulse(LL - 3);
      check("lock_lost_on_3rd_miss", 8'(locked), 8'd0);
      vs_pulse(LL - 3);
      check("relocked", 8'(locked), 8'd1);

      // Misses interrupted by an in-phase pulse, plus one-line tolerance
      repeat (2) begin
         repeat (2) vs_pulse(1);
         vs_pulse(LL);
      end
      repeat (3) vs_pulse(LL - 1);
      repeat (3) vs_pulse(LL + 1);
      check("lock_kept", 8'(locked), 8'd1);

      // Drop lock_en mid-line
      wait_pos($urandom_range(1, 9), $urandom_range(0, VT - 1));
      lock_en = 1'b0;
      @(negedge clk);
      check("unlock_next_clk", 8'(locked), 8'd0);
      #1;
      cyc($urandom_range(5, 30));

      // Random mix of lock_en and vin activity
      lock_en = 1'b1;
      repeat (3000) begin
         if ($urandom_range(0, 299) == 0) lock_en = ~lock_en;
         if ($urandom_range(0, 99) < 3) vin = ~vin;
         cyc(1);
      end
      cyc(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
